led_tone_scheduler: RTL and testbench

Sequences and shares the four color LEDs and the tone generator between three requesters:
- game display playback (DISP)
- player button echo (ECHO)
- sound/light effects (FX: start, win, lose)

It provides the fixed on/gap timing that paces color playback. It replaces the free-running timer pulse with a per-color acknowledge. It sits between the game controller and the LED/buzzer output pins.

---
 rtl/led_tone_scheduler.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_led_tone_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_tone_scheduler.sv
// led_tone_scheduler: shares the four color LEDs and the tone generator
// between display playback (DISP), button echo (ECHO) and effects (FX).
// DISP and ECHO get an on slot followed by a dark gap and a one-cycle ack.
// FX plays four notes from a fixed ROM, then a dark gap and FX_DONE.
// After every ack/done there is one cooldown cycle in which no grant is
// made, so the requester can drop its REQ.
// All outputs are registered from the next state, so LED/TONE/BUSY show
// up in the cycle that follows the grant edge.
// Optional feature: define LED_SPEEDUP_EN to shorten the DISP on-time as
// LEVEL grows (floored at MIN_ON_TICKS). When it is undefined, LEVEL is
// ignored and the DISP on-time is always ON_TICKS.
module led_tone_scheduler #(
  parameter int TICK_DIV      = 1000,
  parameter int ON_TICKS      = 8,
  parameter int GAP_TICKS     = 4,
  parameter int FX_NOTE_TICKS = 6,
  parameter int MIN_ON_TICKS  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DISP_REQ,
  input  logic [1:0] DISP_COLOR,
  output logic       DISP_ACK,
  input  logic       ECHO_REQ,
  input  logic [1:0] ECHO_COLOR,
  output logic       ECHO_ACK,
  input  logic       FX_REQ,
  input  logic [1:0] FX_SEL,
  output logic       FX_DONE,
  input  logic [4:0] LEVEL,
  output logic [3:0] LED,
  output logic       TONE_EN,
  output logic [2:0] TONE_SEL,
  output logic       BUSY
);

  // The phase counter has to hold the longest phase in ticks; MIN_ON_TICKS
  // is included because it can set the DISP on-time when speed-up is on.
  localparam int PH_MAX_A = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
  localparam int PH_MAX_B = (PH_MAX_A > FX_NOTE_TICKS) ? PH_MAX_A : FX_NOTE_TICKS;
  localparam int PH_MAX   = (PH_MAX_B > MIN_ON_TICKS) ? PH_MAX_B : MIN_ON_TICKS;
  localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]   ON_LAST      = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   GAP_LAST     = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0]   NOTE_LAST    = PH_W'(FX_NOTE_TICKS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ON      = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_FX_NOTE = 3'd3;
  localparam logic [2:0] S_FX_GAP  = 3'd4;

  localparam logic OWN_DISP = 1'b0;
  localparam logic OWN_ECHO = 1'b1;

  localparam logic [1:0] FX_START = 2'd0;
  localparam logic [1:0] FX_WIN   = 2'd1;
  localparam logic [1:0] FX_LOSE  = 2'd2;
  localparam logic [1:0] FX_NONE  = 2'd3;

  // Effect note ROM: returns {led[3:0], tone_sel[2:0]} for a note.
  function automatic logic [6:0] fx_rom(input logic [1:0] sel, input logic [1:0] idx);
    logic [6:0] r;
    r = 7'd0;
    case (sel)
      FX_START: r = {4'b0001 << idx, 3'd4 + {1'b0, idx}};
      FX_WIN:   r = {4'b1111, idx[0] ? 3'd6 : 3'd4};
      FX_LOSE:  r = {4'b0000, 3'd7 - {1'b0, idx}};
      default:  r = 7'd0;
    endcase
    return r;
  endfunction

`ifdef LED_SPEEDUP_EN
  // DISP on-time in ticks minus one: ON_TICKS - LEVEL/4, saturated at
  // MIN_ON_TICKS. Done in signed 32-bit so a large LEVEL cannot wrap.
  function automatic logic [PH_W-1:0] disp_on_last(input logic [4:0] lvl);
    logic signed [31:0] t;
    t = ON_TICKS - $signed({27'd0, lvl >> 2});
    if (t < MIN_ON_TICKS) t = MIN_ON_TICKS;
    return PH_W'(t - 1);
  endfunction
`endif

  logic [2:0]        state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [1:0]        note_q, note_d;
  logic              owner_q, owner_d;
  logic [1:0]        color_q, color_d;
  logic [1:0]        fxsel_q, fxsel_d;
  logic              disp_ack_q, disp_ack_d;
  logic              echo_ack_q, echo_ack_d;
  logic              fx_done_q, fx_done_d;
  logic [3:0]        led_q, led_d;
  logic              tone_en_q, tone_en_d;
  logic [2:0]        tone_sel_q, tone_sel_d;
  logic              busy_q, busy_d;

  logic              tick_end;
  logic              cooldown;
  logic [PH_W-1:0]   on_last;
  logic [6:0]        rom_d;

`ifdef LED_SPEEDUP_EN
  logic [4:0]        level_q, level_d;
  assign on_last = (owner_q == OWN_DISP) ? disp_on_last(level_q) : ON_LAST;
`else
  logic              unused_level;
  assign unused_level = ^LEVEL;
  assign on_last      = ON_LAST;
`endif

  assign tick_end = (tick_q == TICK_LAST);
  assign cooldown = disp_ack_q | echo_ack_q | fx_done_q;

  // Next-state logic: arbitration, tick prescaler and phase sequencing.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_end ? '0 : tick_q + 1'b1;
    phase_d    = phase_q;
    note_d     = note_q;
    owner_d    = owner_q;
    color_d    = color_q;
    fxsel_d    = fxsel_q;
    disp_ack_d = 1'b0;
    echo_ack_d = 1'b0;
    fx_done_d  = 1'b0;
`ifdef LED_SPEEDUP_EN
    level_d    = level_q;
`endif
    case (state_q)
      S_IDLE: begin
        tick_d  = '0;
        phase_d = '0;
        note_d  = 2'd0;
        if (!cooldown) begin
          if (FX_REQ) begin
            fxsel_d = FX_SEL;
`ifdef LED_SPEEDUP_EN
            level_d = LEVEL;
`endif
            if (FX_SEL == FX_NONE) fx_done_d = 1'b1;
            else                   state_d   = S_FX_NOTE;
          end else if (ECHO_REQ) begin
            owner_d = OWN_ECHO;
            color_d = ECHO_COLOR;
            state_d = S_ON;
          end else if (DISP_REQ) begin
            owner_d = OWN_DISP;
            color_d = DISP_COLOR;
`ifdef LED_SPEEDUP_EN
            level_d = LEVEL;
`endif
            state_d = S_ON;
          end
        end
      end
      S_ON: begin
        if (tick_end) begin
          if (phase_q == on_last) begin
            state_d = S_GAP;
            phase_d = '0;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (tick_end) begin
          if (phase_q == GAP_LAST) begin
            state_d = S_IDLE;
            phase_d = '0;
            if (owner_q == OWN_ECHO) echo_ack_d = 1'b1;
            else                     disp_ack_d = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_FX_NOTE: begin
        if (tick_end) begin
          if (phase_q == NOTE_LAST) begin
            phase_d = '0;
            if (note_q == 2'd3) state_d = S_FX_GAP;
            else                note_d  = note_q + 2'd1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      S_FX_GAP: begin
        if (tick_end) begin
          if (phase_q == GAP_LAST) begin
            state_d   = S_IDLE;
            phase_d   = '0;
            fx_done_d = 1'b1;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
        phase_d = '0;
      end
    endcase
  end

  // Output decode from the next state so the pins are registered.
  always_comb begin
    led_d      = 4'b0000;
    tone_en_d  = 1'b0;
    tone_sel_d = 3'd0;
    rom_d      = fx_rom(fxsel_d, note_d);
    case (state_d)
      S_ON: begin
        led_d      = 4'b0001 << color_d;
        tone_en_d  = 1'b1;
        tone_sel_d = {1'b0, color_d};
      end
      S_FX_NOTE: begin
        led_d      = rom_d[6:3];
        tone_en_d  = 1'b1;
        tone_sel_d = rom_d[2:0];
      end
      default: begin
        led_d      = 4'b0000;
        tone_en_d  = 1'b0;
        tone_sel_d = 3'd0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Control state, counters and output registers, cleared by RST.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      phase_q    <= '0;
      note_q     <= 2'd0;
      owner_q    <= OWN_DISP;
      disp_ack_q <= 1'b0;
      echo_ack_q <= 1'b0;
      fx_done_q  <= 1'b0;
      led_q      <= 4'b0000;
      tone_en_q  <= 1'b0;
      tone_sel_q <= 3'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      note_q     <= note_d;
      owner_q    <= owner_d;
      disp_ack_q <= disp_ack_d;
      echo_ack_q <= echo_ack_d;
      fx_done_q  <= fx_done_d;
      led_q      <= led_d;
      tone_en_q  <= tone_en_d;
      tone_sel_q <= tone_sel_d;
      busy_q     <= busy_d;
    end
  end

  // Latched request payload; only meaningful while a slot is active.
  always_ff @(posedge CLK) begin
    color_q <= color_d;
    fxsel_q <= fxsel_d;
`ifdef LED_SPEEDUP_EN
    level_q <= level_d;
`endif
  end

  assign LED      = led_q;
  assign TONE_EN  = tone_en_q;
  assign TONE_SEL = tone_sel_q;
  assign BUSY     = busy_q;
  assign DISP_ACK = disp_ack_q;
  assign ECHO_ACK = echo_ack_q;
  assign FX_DONE  = fx_done_q;

endmodule

// File: tb/tb_led_tone_scheduler.sv
// Testbench for led_tone_scheduler with TICK_DIV=2, ON_TICKS=3,
// GAP_TICKS=1, FX_NOTE_TICKS=2, MIN_ON_TICKS=1. A table of per-row
// inputs and expected outputs (held for n cycles) covers reset, arbitration,
// effects and cooldown; hand-written sequences cover waiting requests,
// mid-slot reset and the LEVEL floor.
module tb_led_tone_scheduler;

  logic       clk;
  logic       rst;
  logic       dq, eq, fq;
  logic [1:0] dc, ec, fs;
  logic [4:0] lv;
  logic       disp_ack, echo_ack, fx_done, tone_en, busy;
  logic [3:0] led;
  logic [2:0] tone_sel;
  logic [11:0] out_vec;

  int n_tests;
  int n_fail;

`ifdef LED_SPEEDUP_EN
  localparam int ON_L8  = 2;
  localparam int ON_L31 = 2;
`else
  localparam int ON_L8  = 6;
  localparam int ON_L31 = 6;
`endif

  led_tone_scheduler #(
    .TICK_DIV(2), .ON_TICKS(3), .GAP_TICKS(1), .FX_NOTE_TICKS(2), .MIN_ON_TICKS(1)
  ) dut (
    .CLK(clk), .RST(rst),
    .DISP_REQ(dq), .DISP_COLOR(dc), .DISP_ACK(disp_ack),
    .ECHO_REQ(eq), .ECHO_COLOR(ec), .ECHO_ACK(echo_ack),
    .FX_REQ(fq), .FX_SEL(fs), .FX_DONE(fx_done),
    .LEVEL(lv), .LED(led), .TONE_EN(tone_en), .TONE_SEL(tone_sel), .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign out_vec = {led, tone_en, tone_sel, busy, disp_ack, echo_ack, fx_done};

  typedef struct {
    logic        rst, dq;
    logic [1:0]  dc;
    logic        eq;
    logic [1:0]  ec;
    logic        fq;
    logic [1:0]  fs;
    logic [4:0]  lv;
    logic [11:0] exp;
    int          n;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [11:0] ex(input logic [3:0] l, input logic en, input logic [2:0] ts,
                                     input logic b, input logic da, input logic ea, input logic fd);
    return {l, en, ts, b, da, ea, fd};
  endfunction

  function automatic vec_t v(input logic r, input logic d, input logic [1:0] dcol,
                             input logic e, input logic [1:0] ecol,
                             input logic f, input logic [1:0] fsel, input logic [4:0] lvl,
                             input logic [11:0] x, input int n);
    vec_t t;
    t.rst = r; t.dq = d; t.dc = dcol; t.eq = e; t.ec = ecol;
    t.fq = f; t.fs = fsel; t.lv = lvl; t.exp = x; t.n = n;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  initial begin
    int cnt;
    int seen;
    logic [11:0] Z;
    n_tests = 0;
    n_fail  = 0;
    Z = 12'd0;
    rst = 1'b1; dq = 0; dc = 0; eq = 0; ec = 0; fq = 0; fs = 0; lv = 0;

    // Reset held with all requests active, then FX start wins.
    tbl.push_back(v(1,1,2,1,1,1,0,0, Z, 2));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b0001,1,4,1,0,0,0), 4));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b0010,1,5,1,0,0,0), 4));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b0100,1,6,1,0,0,0), 4));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b1000,1,7,1,0,0,0), 4));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b0000,0,0,1,0,0,0), 2));
    tbl.push_back(v(0,1,2,1,1,1,0,0, ex(4'b0000,0,0,0,0,0,1), 1));
    // Cooldown, then ECHO beats DISP; ECHO_REQ dropped after its grant.
    tbl.push_back(v(0,1,2,1,1,0,0,0, Z, 1));
    tbl.push_back(v(0,1,2,1,1,0,0,0, ex(4'b0010,1,1,1,0,0,0), 1));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0010,1,1,1,0,0,0), 5));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0000,0,0,1,0,0,0), 2));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0000,0,0,0,0,1,0), 1));
    // DISP color 2; REQ still high through the ack and cooldown cycles.
    tbl.push_back(v(0,1,2,0,1,0,0,0, Z, 1));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0100,1,2,1,0,0,0), 6));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0000,0,0,1,0,0,0), 2));
    tbl.push_back(v(0,1,2,0,1,0,0,0, ex(4'b0000,0,0,0,1,0,0), 1));
    tbl.push_back(v(0,1,2,0,1,0,0,0, Z, 1));
    tbl.push_back(v(0,0,2,0,1,0,0,0, Z, 2));
    // FX win and DISP raised together: FX first, then DISP with LEVEL=8.
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b1111,1,4,1,0,0,0), 4));
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b1111,1,6,1,0,0,0), 4));
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b1111,1,4,1,0,0,0), 4));
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b1111,1,6,1,0,0,0), 4));
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b0000,0,0,1,0,0,0), 2));
    tbl.push_back(v(0,1,0,0,0,1,1,0, ex(4'b0000,0,0,0,0,0,1), 1));
    tbl.push_back(v(0,1,0,0,0,0,1,8, Z, 1));
    tbl.push_back(v(0,1,0,0,0,0,1,8, ex(4'b0001,1,0,1,0,0,0), ON_L8));
    tbl.push_back(v(0,1,0,0,0,0,1,8, ex(4'b0000,0,0,1,0,0,0), 2));
    tbl.push_back(v(0,1,0,0,0,0,1,8, ex(4'b0000,0,0,0,1,0,0), 1));
    tbl.push_back(v(0,0,0,0,0,0,1,8, Z, 1));
    // Reserved effect: immediate FX_DONE, no activity.
    tbl.push_back(v(0,0,0,0,0,1,3,0, ex(4'b0000,0,0,0,0,0,1), 1));
    tbl.push_back(v(0,0,0,0,0,0,3,0, Z, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; dq = tbl[i].dq; dc = tbl[i].dc; eq = tbl[i].eq;
      ec = tbl[i].ec; fq = tbl[i].fq; fs = tbl[i].fs; lv = tbl[i].lv;
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        n_tests++;
        if (out_vec !== tbl[i].exp) begin
          n_fail++;
          $display("FAIL row%0d cyc%0d outputs {led,en,sel,busy,da,ea,fd}: got %b, expected %b",
                   i, k, out_vec, tbl[i].exp);
        end
      end
    end

    // ECHO raised during DISP ON waits for DISP_ACK plus cooldown.
    dq = 1; dc = 3; lv = 0;
    step();
    chk("disp3_led", int'(led), 8);
    step();
    eq = 1; ec = 1;
    seen = 0;
    for (int i = 0; i < 40 && !disp_ack; i++) begin
      step();
      if (led == 4'b0010) seen = 1;
    end
    chk("disp3_ack", int'(disp_ack), 1);
    chk("echo_waited", seen, 0);
    dq = 0;
    step();
    chk("echo_cooldown", int'({led, busy, echo_ack}), 0);
    step();
    chk("echo_grant_led", int'(led), 2);
    chk("echo_grant_tone", int'(tone_sel), 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (led == 4'b0010) cnt++;
      else break;
    end
    chk("echo_on_cycles", cnt, 6);
    for (int i = 0; i < 40 && !echo_ack; i++) step();
    chk("echo_ack", int'(echo_ack), 1);
    eq = 0;
    step();

    // RST in the third ON cycle aborts the slot without an ack.
    dq = 1; dc = 1;
    step();
    chk("pre_rst_led", int'(led), 2);
    step();
    step();
    rst = 1;
    step();
    chk("mid_rst_dark", int'({led, tone_en, busy}), 0);
    rst = 0; dq = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (disp_ack) cnt++;
    end
    chk("mid_rst_no_ack", cnt, 0);

    // LEVEL=31: speed-up saturates at MIN_ON_TICKS.
    dq = 1; dc = 0; lv = 31;
    step();
    chk("l31_led", int'(led), 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (led == 4'b0001) cnt++;
      else break;
    end
    chk("l31_on_cycles", cnt, ON_L31);
    for (int i = 0; i < 40 && !disp_ack; i++) step();
    chk("l31_ack", int'(disp_ack), 1);
    dq = 0;
    step();
    chk("l31_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
